// File: rtl/midi_msg_parser.sv
// Decodes a MIDI byte stream into single-cycle channel-voice events and real-time pulses.
// Latency: events and rt_* pulses are registered on the clk edge that samples the deciding byte.
// Backpressure: none; one byte is accepted per rx_ready strobe and every strobe is consumed.
module midi_msg_parser #(
    parameter bit VEL0_IS_OFF = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    input  logic [3:0] channel,
    input  logic       omni,
    output logic       ev_valid,
    output logic [2:0] ev_type,
    output logic [3:0] ev_chan,
    output logic [6:0] ev_d1,
    output logic [6:0] ev_d2,
    output logic       rt_clock,
    output logic       rt_start,
    output logic       rt_stop,
    output logic [1:0] parse_state
);

    // Running status is valid exactly when the FSM is in WAIT_D1 or WAIT_D2;
    // IDLE and SYSEX both mean "no usable status".
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2,
        SYSEX   = 2'd3
    } state_t;

    state_t     state_q, state_nxt;
    logic [6:0] status_q, status_nxt;   // bit 7 of a status byte is always 1, not stored
    logic [6:0] d1_q, d1_nxt;

    logic       emit;
    logic [6:0] emit_d1;
    logic [6:0] emit_d2;
    logic [2:0] emit_type;
    logic       chan_ok;
    logic       one_byte;
    logic       is_rt;
    logic       rt_clock_c, rt_start_c, rt_stop_c;

    // Cx (program change) and Dx (channel pressure) carry a single data byte.
    assign one_byte = (status_q[6:5] == 2'b10);
    assign is_rt    = (rx_data[7:3] == 5'b11111);

    // Filter is evaluated against channel/omni as they stand when the message completes.
    assign chan_ok  = omni || (status_q[3:0] == channel);

    // Status high nibble 8..E maps directly onto event types 0..6 via bits [6:4].
    always_comb begin
        emit_type = status_q[6:4];
        if (VEL0_IS_OFF && (status_q[6:4] == 3'd1) && (emit_d2 == 7'd0)) begin
            emit_type = 3'd0;
        end
    end

    // State register; an asynchronous reset discards any partial message.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            status_q <= 7'd0;
            d1_q     <= 7'd0;
        end else begin
            state_q  <= state_nxt;
            status_q <= status_nxt;
            d1_q     <= d1_nxt;
        end
    end

    // Next-state decode: classify the strobed byte and decide whether it completes a message.
    always_comb begin
        state_nxt  = state_q;
        status_nxt = status_q;
        d1_nxt     = d1_q;
        emit       = 1'b0;
        emit_d1    = 7'd0;
        emit_d2    = 7'd0;
        rt_clock_c = 1'b0;
        rt_start_c = 1'b0;
        rt_stop_c  = 1'b0;
        if (rx_ready) begin
            if (is_rt) begin
                // Real-time bytes interleave transparently; only 0xFF disturbs parsing.
                case (rx_data[2:0])
                    3'd0:    rt_clock_c = 1'b1;
                    3'd2,
                    3'd3:    rt_start_c = 1'b1;
                    3'd4:    rt_stop_c  = 1'b1;
                    3'd7:    state_nxt  = IDLE;
                    default: ;
                endcase
            end else if (rx_data[7]) begin
                if (rx_data[7:4] != 4'hF) begin
                    status_nxt = rx_data[6:0];
                    state_nxt  = WAIT_D1;
                end else if (rx_data == 8'hF0) begin
                    state_nxt  = SYSEX;
                end else begin
                    // System common (incl. F7 end-of-SysEx) cancels running status.
                    state_nxt  = IDLE;
                end
            end else begin
                case (state_q)
                    WAIT_D1: begin
                        d1_nxt = rx_data[6:0];
                        if (one_byte) begin
                            emit    = 1'b1;
                            emit_d1 = rx_data[6:0];
                        end else begin
                            state_nxt = WAIT_D2;
                        end
                    end
                    WAIT_D2: begin
                        emit      = 1'b1;
                        emit_d1   = d1_q;
                        emit_d2   = rx_data[6:0];
                        state_nxt = WAIT_D1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output registers: pulses last one clock, event fields hold until the next accepted event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ev_valid <= 1'b0;
            ev_type  <= 3'd0;
            ev_chan  <= 4'd0;
            ev_d1    <= 7'd0;
            ev_d2    <= 7'd0;
            rt_clock <= 1'b0;
            rt_start <= 1'b0;
            rt_stop  <= 1'b0;
        end else begin
            ev_valid <= emit && chan_ok;
            rt_clock <= rt_clock_c;
            rt_start <= rt_start_c;
            rt_stop  <= rt_stop_c;
            if (emit && chan_ok) begin
                ev_type <= emit_type;
                ev_chan <= status_q[3:0];
                ev_d1   <= emit_d1;
                ev_d2   <= emit_d2;
            end
        end
    end

    assign parse_state = state_q;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Self-checking bench for midi_msg_parser: directed byte sequences then random streams.
// Every strobed byte is applied to a message-level reference model and all outputs compared.
// No backpressure exists; random idle gaps with garbage rx_data verify that outputs hold.
module tb_midi_msg_parser;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic [3:0] channel;
    logic       omni;
    logic       ev_valid;
    logic [2:0] ev_type;
    logic [3:0] ev_chan;
    logic [6:0] ev_d1;
    logic [6:0] ev_d2;
    logic       rt_clock;
    logic       rt_start;
    logic       rt_stop;
    logic [1:0] parse_state;

    int checks   = 0;
    int failures = 0;

    // Reference model: message-level view (status byte, collected data count, sysex flag).
    int  m_rs;      // running status byte, -1 when invalid
    bit  m_sx;      // inside a SysEx dump
    int  m_nd;      // data bytes collected for current message
    int  m_d1;
    bit  m_vld, m_clk, m_start, m_stop;
    int  e_type, e_chan, e_d1, e_d2;

    midi_msg_parser #(.VEL0_IS_OFF(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .channel    (channel),
        .omni       (omni),
        .ev_valid   (ev_valid),
        .ev_type    (ev_type),
        .ev_chan    (ev_chan),
        .ev_d1      (ev_d1),
        .ev_d2      (ev_d2),
        .rt_clock   (rt_clock),
        .rt_start   (rt_start),
        .rt_stop    (rt_stop),
        .parse_state(parse_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rs = -1; m_sx = 0; m_nd = 0; m_d1 = 0;
        m_vld = 0; m_clk = 0; m_start = 0; m_stop = 0;
        e_type = 0; e_chan = 0; e_d1 = 0; e_d2 = 0;
    endtask

    task automatic model_emit(input int d1, input int d2);
        if (omni || ((m_rs % 16) == channel)) begin
            m_vld  = 1;
            e_type = (m_rs / 16) - 8;
            if (e_type == 1 && d2 == 0) e_type = 0;
            e_chan = m_rs % 16;
            e_d1   = d1;
            e_d2   = d2;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        int need;
        m_vld = 0; m_clk = 0; m_start = 0; m_stop = 0;
        if (b >= 8'hF8) begin
            if (b == 8'hF8) m_clk = 1;
            if (b == 8'hFA || b == 8'hFB) m_start = 1;
            if (b == 8'hFC) m_stop = 1;
            if (b == 8'hFF) begin m_rs = -1; m_sx = 0; m_nd = 0; end
        end else if (b >= 8'h80 && b < 8'hF0) begin
            m_rs = b; m_sx = 0; m_nd = 0;
        end else if (b == 8'hF0) begin
            m_sx = 1; m_rs = -1; m_nd = 0;
        end else if (b > 8'hF0) begin
            m_sx = 0; m_rs = -1; m_nd = 0;
        end else if (!m_sx && m_rs >= 0) begin
            need = ((m_rs / 16) == 12 || (m_rs / 16) == 13) ? 1 : 2;
            if (m_nd == 0) begin
                m_d1 = b;
                if (need == 1) model_emit(b, 0);
                else m_nd = 1;
            end else begin
                model_emit(m_d1, b);
                m_nd = 0;
            end
        end
    endtask

    function automatic int exp_state();
        if (m_sx) return 3;
        if (m_rs < 0) return 0;
        return (m_nd == 1) ? 2 : 1;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".ev_valid"}, ev_valid, m_vld);
        check({tag, ".ev_type"},  ev_type,  e_type);
        check({tag, ".ev_chan"},  ev_chan,  e_chan);
        check({tag, ".ev_d1"},    ev_d1,    e_d1);
        check({tag, ".ev_d2"},    ev_d2,    e_d2);
        check({tag, ".rt_clock"}, rt_clock, m_clk);
        check({tag, ".rt_start"}, rt_start, m_start);
        check({tag, ".rt_stop"},  rt_stop,  m_stop);
        check({tag, ".state"},    parse_state, exp_state());
    endtask

    // One strobe, check outputs one clock later, then 0..2 idle cycles with junk on rx_data.
    task automatic send(input logic [7:0] b, input string tag);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        model_byte(b);
        @(negedge clk);
        rx_ready = 1'b0;
        rx_data  = 8'($urandom);
        check_all(tag);
        m_vld = 0; m_clk = 0; m_start = 0; m_stop = 0;
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            rx_data = 8'($urandom);
            check_all({tag, ".idle"});
        end
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        r = $urandom_range(0, 99);
        if (r < 55) return 8'($urandom_range(0, 127));
        if (r < 77) return 8'($urandom_range(8'h80, 8'hEF));
        if (r < 90) return 8'($urandom_range(8'hF8, 8'hFF));
        return 8'($urandom_range(8'hF0, 8'hF7));
    endfunction

    initial begin
        logic [7:0] seq [$];
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_ready = 1'b0;
        channel  = 4'd0;
        omni     = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        reset = 1'b0;

        // Basic Note On, one clock after the third strobe.
        send(8'h90, "t1"); send(8'h3C, "t1"); send(8'h64, "t1.ev");
        check("t1.d1_const", ev_d1, 7'h3C);

        // Running status with velocity-0 Note On reported as Note Off.
        send(8'h93, "t2"); send(8'h40, "t2"); send(8'h7F, "t2.on");
        send(8'h41, "t2"); send(8'h00, "t2.off");
        check("t2.type_off", ev_type, 3'd0);

        // Real-time clock interleaved inside a message.
        send(8'h90, "t3"); send(8'h3C, "t3"); send(8'hF8, "t3.clk"); send(8'h64, "t3.ev");

        // Channel filter.
        omni = 1'b0; channel = 4'd2;
        send(8'hC5, "t4"); send(8'h07, "t4.filt");
        send(8'hC2, "t4"); send(8'h09, "t4.pc");
        check("t4.chan_const", ev_chan, 4'd2);
        omni = 1'b1;

        // SysEx skipped, then pitch bend.
        seq = '{8'hF0, 8'h7E, 8'h01, 8'hF7, 8'h45, 8'hE1, 8'h00, 8'h40};
        foreach (seq[i]) send(seq[i], "t5");
        check("t5.pb_msb", ev_d2, 7'h40);

        // Abort by new status, then asynchronous reset mid-message.
        send(8'hB0, "t6"); send(8'h07, "t6"); send(8'h80, "t6.abort");
        send(8'hB0, "t6"); send(8'h07, "t6");
        send(8'hFA, "t6.start"); send(8'hFC, "t6.stop");
        send(8'h90, "t6"); send(8'h11, "t6");
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        check_all("t6.reset");
        @(negedge clk);
        reset = 1'b0;

        // Random byte streams with occasional filter changes.
        for (int n = 0; n < 1500; n++) begin
            if (n % 60 == 0) begin
                omni    = 1'($urandom_range(0, 1));
                channel = 4'($urandom);
            end
            send(rand_byte(), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #2000000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
